// File: rtl/booth_mult_pkg.sv
// Shared types for the radix-4 Booth multiplier: FSM states and Booth recode digits.
package booth_mult_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    typedef enum logic [2:0] {
        ZERO,
        PM,
        P2M,
        NM,
        N2M
    } booth_t;

endpackage

// File: rtl/booth_enc.sv
// Radix-4 Booth recoder: maps a 3-bit window {b[i+1], b[i], b[i-1]} to a multiple of M.
module booth_enc
    import booth_mult_pkg::*;
(
    input  logic [2:0] bits,
    output booth_t     code
);

    always_comb begin
        code = ZERO;
        case (bits)
            3'b001, 3'b010: code = PM;
            3'b011:         code = P2M;
            3'b100:         code = N2M;
            3'b101, 3'b110: code = NM;
            default:        code = ZERO;
        endcase
    end

endmodule

// File: rtl/booth_mult.sv
// Sequential signed radix-4 Booth multiplier, WIDTH/2 iterations per product.
// Define BOOTH_OVF_EN to build the signed-overflow (exception) flag; otherwise it is tied low.
module booth_mult
    import booth_mult_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic [WIDTH-1:0] result,
    output logic             result_rdy,
    output logic             busy,
    output logic             exception
);

    localparam int PW    = 2 * WIDTH + 3;
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH / 2 - 1);

    if ((WIDTH < 4) || (WIDTH % 2 != 0)) begin : g_width_check
        $error("booth_mult: WIDTH must be even and at least 4");
    end

    state_t                   state;
    state_t                   state_nxt;
    logic [CNT_W-1:0]         cnt;
    logic signed [WIDTH-1:0]  m;
    logic signed [PW-1:0]     prod;
    logic signed [PW-1:0]     prod_nxt;
    logic signed [WIDTH+1:0]  m_ext;
    logic signed [WIDTH+1:0]  m_dbl;
    logic signed [WIDTH+1:0]  addend;
    logic signed [WIDTH+1:0]  acc;
    booth_t                   code;
    logic                     accept;
    logic                     last;

    assign accept = start && (state != RUN);
    assign last   = (state == RUN) && (cnt == LAST);

    booth_enc u_enc (
        .bits (prod[2:0]),
        .code (code)
    );

    // Partial-product selection, add into the upper WIDTH+2 bits, then arithmetic shift by 2.
    assign m_ext = {{2{m[WIDTH-1]}}, m};
    assign m_dbl = {m[WIDTH-1], m, 1'b0};

    always_comb begin
        addend = '0;
        case (code)
            PM:      addend = m_ext;
            P2M:     addend = m_dbl;
            NM:      addend = -m_ext;
            N2M:     addend = -m_dbl;
            default: addend = '0;
        endcase
        acc      = prod[PW-1 -: WIDTH+2] + addend;
        prod_nxt = $signed({acc, prod[WIDTH:0]}) >>> 2;
    end

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last)  state_nxt = DONE;
            DONE:    state_nxt = start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        result_rdy = (state == DONE);
        busy       = (state == RUN);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt    <= '0;
            result <= '0;
        end else if (accept) begin
            cnt <= '0;
        end else if (state == RUN) begin
            cnt <= cnt + 1'b1;
            if (last) result <= prod_nxt[WIDTH:1];
        end
    end

    always_ff @(posedge clock) begin
        if (accept) begin
            m    <= operand_a;
            prod <= {{(WIDTH + 2){1'b0}}, operand_b, 1'b0};
        end else if (state == RUN) begin
            prod <= prod_nxt;
        end
    end

`ifdef BOOTH_OVF_EN
    logic             exc;
    logic [WIDTH-1:0] prod_hi;
    logic             ovf;

    // Overflow when the upper half of the 2*WIDTH product is not a pure sign extension.
    assign prod_hi = prod_nxt[2*WIDTH:WIDTH+1];
    assign ovf     = (prod_hi != {WIDTH{prod_nxt[WIDTH]}});

    always_ff @(posedge clock) begin
        if (reset)     exc <= 1'b0;
        else if (last) exc <= ovf;
    end

    assign exception = exc;
`else
    assign exception = 1'b0;
`endif

endmodule

// File: doc/booth_mult.md
BOOTH_MULT -- requirements
Module: booth_mult

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, operand/result width; it SHALL be even and at least 4.
REQ-002 Port clock SHALL be input, width 1, the single clock; all state SHALL update on its rising edge.
REQ-003 Port reset SHALL be input, width 1, and SHALL be a synchronous, active-high reset.
REQ-004 Port start SHALL be input, width 1, a request to begin a multiply, sampled each cycle.
REQ-005 Port operand_a SHALL be input, width WIDTH, the signed multiplicand, sampled on an accepted start.
REQ-006 Port operand_b SHALL be input, width WIDTH, the signed multiplier, sampled on an accepted start.
REQ-007 Port result SHALL be output, width WIDTH, the low WIDTH bits of the signed product.
REQ-008 Port result_rdy SHALL be output, width 1, a one-cycle pulse marking result valid.
REQ-009 Port busy SHALL be output, width 1, high while an operation is in progress.
REQ-010 Port exception SHALL be output, width 1, signed-overflow flag, valid with result_rdy.

Function
REQ-011 The block SHALL use states IDLE, RUN and DONE.
REQ-012 In IDLE or DONE with start=1: latch M=operand_a, load the product register as {zeros(WIDTH+2), operand_b, 1'b0}, clear the iteration counter, go to RUN.
REQ-013 Each RUN cycle: recode the product register bits [2:0] as radix-4 Booth (0, +M, +2M, -2M, -M), add to the upper WIDTH+2 bits (M sign-extended), arithmetic-shift the register right by 2, increment the counter.
REQ-014 After exactly WIDTH/2 RUN cycles (16 for WIDTH=32), go to DONE; DONE lasts one cycle unless a start is accepted, then go to IDLE.
REQ-015 Latency: start accepted in cycle 0 -> result_rdy=1 in cycle WIDTH/2+1.
REQ-016 result_rdy SHALL be 1 only in DONE; busy SHALL be 1 only in RUN.
REQ-017 result SHALL hold the last completed product until the next completion or reset; it SHALL NOT change during RUN.
REQ-018 start while busy=1 SHALL be ignored, with no effect on operands or timing.
REQ-019 start in the DONE cycle SHALL be accepted (back-to-back), so result_rdy pulses exactly every WIDTH/2+1 cycles.
REQ-020 Operand changes after acceptance SHALL NOT affect the result.

Reset
REQ-021 reset=1 SHALL force IDLE, result=0, result_rdy=0, busy=0, exception=0, counter=0 at the next edge, including mid-RUN and over a simultaneous start; no result_rdy SHALL follow an aborted operation.

Configuration
REQ-022 With BOOTH_OVF_EN defined, exception SHALL be 1 in DONE iff the full 2*WIDTH-bit product's upper WIDTH bits are not all equal to result[WIDTH-1]; it SHALL hold with result.
REQ-023 Without BOOTH_OVF_EN, exception SHALL be constant 0 and no overflow logic SHALL be synthesised.

Structure
REQ-024 A shared package SHALL hold the state enum (IDLE/RUN/DONE) and the Booth recode enum (ZERO, PM, P2M, NM, N2M).
REQ-025 The combinational recoder SHALL be a sub-module booth_enc: in 3 bits, out recode enum; all sequencing SHALL stay in booth_mult.

Verification
REQ-026 3*5, start at cycle 0 -> result=15, result_rdy=1 at cycle 17 only, exception=0.
REQ-027 -7*6 -> result=0xFFFFFFD6 (-42), exception=0; 0*0x80000000 -> 0, exception=0.
REQ-028 0x7FFFFFFF*2 -> result=0xFFFFFFFE, exception=1; 0x80000000*0xFFFFFFFF -> result=0x80000000, exception=1 (0 without BOOTH_OVF_EN).
REQ-029 reset asserted at cycle 8 of a run -> busy=0 at cycle 9, result=0, no result_rdy within 40 cycles.
REQ-030 start held high continuously with new operands each cycle -> result_rdy every 17 cycles, each result matches the operands sampled at its accepting cycle; mid-run operands are ignored.
